rgb_pwm_driver: RTL
===================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 4: clock cycles per PWM step; legal range 1..65535.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  1 = PWM running, 0 = outputs forced off.
REQ-005 rgb  input  24  colour from the rgb converter: [23:16] R duty, [15:8] G duty, [7:0] B duty.
REQ-006 led_r  output  1  red PWM drive, registered.
REQ-007 led_g  output  1  green PWM drive, registered.
REQ-008 led_b  output  1  blue PWM drive, registered.
REQ-009 period_start  output  1  one-cycle pulse, registered, marks duty reload.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-011 IDLE -> RUN SHALL occur on the first clock edge with enable=1; RUN -> IDLE SHALL occur on the first clock edge with enable=0.
REQ-012 A prescaler p SHALL count 0..PRESCALE-1 in RUN; step tick = (p == PRESCALE-1); p wraps to 0 on tick.
REQ-013 An 8-bit step counter cnt SHALL increment on each tick in RUN and wrap 255 -> 0; one PWM period = 256*PRESCALE clocks.
REQ-014 Three 8-bit shadow duty registers duty_r/g/b SHALL load rgb fields on the IDLE -> RUN edge and on the edge where tick occurs with cnt==255; at no other time.
REQ-015 rgb changes mid-period SHALL have no effect until the next shadow load (glitch-free, no partial periods).
REQ-016 period_start SHALL be 1 for exactly the cycle after each shadow load, else 0.
REQ-017 Each cycle in RUN, led_x SHALL be registered from (cnt < duty_x) using current-cycle cnt/duty, i.e. one-cycle output latency.
REQ-018 duty 0 SHALL give led_x constantly 0; duty N SHALL give exactly N*PRESCALE high cycles per period, contiguous, starting at period start; duty 255 gives 255*PRESCALE high, PRESCALE low.
REQ-019 In IDLE: p=0, cnt=0, led_r/g/b=0, period_start=0; shadow registers hold.
REQ-020 enable dropping mid-period SHALL force led_x=0 on the next edge, abandoning the period; re-enable SHALL start a fresh full period with reloaded duties.
REQ-021 With PRESCALE=1, tick SHALL be asserted every RUN cycle.
REQ-022 rgb SHALL be sampled only at shadow load, so the 1-cycle BRAM read latency upstream needs no extra handling.

Reset
REQ-023 On an edge with rst_n=0: state=IDLE, p=0, cnt=0, duty_r/g/b=0, led_r/g/b=0, period_start=0.
REQ-024 rst_n=0 SHALL override enable; reset mid-period SHALL abandon the period with no output glitch beyond the reset edge.
REQ-025 After rst_n returns to 1 with enable=1, RUN SHALL be entered on the next edge, as per REQ-011.

Verification
REQ-026 PRESCALE=1, rgb=0x8000FF, enable=1 after reset -> per 256-clock period: led_r high 128, led_g high 0, led_b high 255; period_start every 256 clocks.
REQ-027 PRESCALE=4, rgb=0x010000 -> led_r high exactly 4 consecutive clocks per 1024-clock period.
REQ-028 PRESCALE=1, rgb 0x400000 -> 0xC00000 at cnt=10 -> current period led_r high 64; next period high 192; first changed period aligned to period_start.
REQ-029 PRESCALE=1, enable dropped at cnt=50 with duty_r=200 -> led_r=0 on the next edge; enable re-raised -> period_start pulse, full 200-high period from cnt=0.
REQ-030 rst_n=0 for one edge mid-period, rgb=0xFFFFFF -> all outputs 0 and cnt=0 on the next cycle; the first period after reset shows 255-high for each channel.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel 8-bit PWM with period-aligned duty reload and enable gating.
module rgb_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_start
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] p;
  logic [7:0] cnt, duty_r, duty_g, duty_b;
  logic tick, load, active;
  assign tick = p == PW'(PRESCALE - 1);
  assign active = state == RUN && enable;
  always_comb begin
    state_nxt = enable ? RUN : IDLE;
    load = (state == IDLE && enable) || (active && tick && cnt == 8'hff);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Duties are only sampled at load, so rgb may change freely mid-period.
  always_ff @(posedge clk)
    if (!rst_n) begin
      p <= '0;
      cnt <= '0;
      {duty_r, duty_g, duty_b} <= '0;
      {led_r, led_g, led_b} <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= load;
      if (load) {duty_r, duty_g, duty_b} <= rgb;
      if (active) begin
        led_r <= cnt < duty_r;
        led_g <= cnt < duty_g;
        led_b <= cnt < duty_b;
        p <= tick ? '0 : p + PW'(1);
        cnt <= cnt + 8'(tick);
      end else begin
        p <= '0;
        cnt <= '0;
        {led_r, led_g, led_b} <= '0;
      end
    end
endmodule
